tdm_demux_1x8: RTL and testbench
================================

Name: tdm_demux_1x8

Overview:
- Sequential 1-to-8 time-division demultiplexer, the receive-side counterpart of the 8:1 channel mux.
- Takes one serial bit per accepted beat and steers it into channel slot 0..7 using an internal channel counter.
- Presents the assembled 8-channel word on a registered parallel output with valid/ready handshake.
- Sits behind any serial/TDM source in the SD122 datapath labs.

Parameters:
- CH, 8, number of channels; fixed at 8 for this block (counter width 3).
- MSB_FIRST, 0: 0 = first accepted bit goes to channel 0; 1 = first bit goes to channel 7.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- sync_clr  input  1  synchronous frame restart, active-high.
- din  input  1  serial channel bit.
- din_valid  input  1  din is valid this cycle.
- din_ready  output  1  block can accept din this cycle.
- dout  output  8  assembled channel word; bit i = channel i.
- dout_valid  output  1  dout holds an unconsumed word.
- dout_ready  input  1  downstream consumes dout this cycle.
- ch_idx  output  3  slot that the next accepted bit will fill.

Behaviour:
- Reset: rst_n low asynchronously forces dout=0, dout_valid=0, ch_idx=0, collect register=0, state=COLLECT. din_ready=0 while rst_n is low.
- Beat accepted on a rising edge when din_valid && din_ready.
- Slot selection: slot = count when MSB_FIRST=0; slot = 7-count when MSB_FIRST=1. ch_idx reports that slot.
- Counter: count advances 0..7 by one per accepted beat and wraps 7->0. With no beat, count and ch_idx hold.
- States:
  - COLLECT: din_ready=1.
  - STALL: din_ready=0. A complete word is waiting in the collect register.
- On the beat with count=7: word = collect register with the new bit merged in.
  - If !dout_valid || dout_ready: dout<=word, dout_valid<=1, count<=0, stay in COLLECT.
  - Otherwise: hold word in the collect register, count<=0, go to STALL.
- In STALL, on dout_ready=1: dout<=collect word, dout_valid stays 1, go to COLLECT. din_ready=1 from the next cycle.
- dout_valid clears on a cycle with dout_valid && dout_ready when no new word is loaded that edge.
- Simultaneous consume + load: the new word replaces the old one with dout_valid held at 1, no bubble.
- Latency: 8th bit accepted at edge k gives dout/dout_valid updated at edge k. Sustained throughput is 8 bits per word with no gaps.
- din_valid gaps: no effect except that counting pauses.
- dout is stable while dout_valid=1 and dout_ready=0.
- sync_clr=1 at an edge has priority over all other actions:
  - count=0, collect register=0, dout_valid=0, dout=0, state=COLLECT.
  - Partial frame is discarded; the beat presented that cycle is dropped.
- Reset asserted mid-frame: discards all state immediately. The first beat after release fills slot 0 (or 7 when MSB_FIRST=1).

Optional Feature:
- Macro: TDM_DEMUX_PARITY_EN.
- Defined:
  - Frame is 9 beats: 8 data bits followed by one even-parity bit. count runs 0..8; ch_idx=0 during the parity beat.
  - Output port parity_err (1 bit) is added. It is registered with dout, equals XOR of the 8 data bits and the parity bit, and is meaningful only while dout_valid=1.
  - Load/STALL decision happens on the parity beat.
  - Reset and sync_clr clear parity_err.
- Undefined: 8-beat frames and no parity_err port.

Test Plan:
- Reset: hold rst_n=0 with din_valid=1 -> dout=8'h00, dout_valid=0, ch_idx=0, din_ready=0. After release, din_ready=1.
- Basic frame: MSB_FIRST=0, dout_ready=1, continuous bits 1,0,1,1,0,0,1,0 -> dout=8'h4D with a one-cycle dout_valid pulse at the 8th accept edge. Same stream with MSB_FIRST=1 -> dout=8'hB2.
- Backpressure: dout_ready=0, frames 8'hA5 then 8'h3C.
  - After the 16th bit: dout=8'hA5 with din_ready=0 (STALL).
  - Raise dout_ready one cycle -> dout=8'h3C, dout_valid=1, din_ready=1 next cycle.
  - Further dout_ready -> dout_valid=0.
- Gapped input: 8'h4D with random din_valid gaps of 0-3 cycles -> ch_idx holds across gaps, result 8'h4D, no extra dout_valid pulses.
- Restart:
  - sync_clr after 5 bits of all-ones -> ch_idx=0, dout_valid=0; next 8 bits 1 -> dout=8'hFF.
  - Separately, rst_n pulsed after 3 bits -> next 8 bits 0x0F (LSB first) give 8'h0F.
- Parity (macro defined): 8'h4D plus parity bit 0 -> parity_err=0; 8'h4D plus parity bit 1 -> parity_err=1; dout=8'h4D in both cases.

Source files
------------

// File: rtl/tdm_demux_1x8.sv
// tdm_demux_1x8 : 1-to-8 time-division demultiplexer.
// One serial bit per accepted beat is steered into channel slot 0..7, and the
// assembled word is presented on a registered output with a valid/ready handshake.
// A complete word that arrives while the output is still occupied is parked in
// the collect register (STALL) until the downstream consumes the current word.
// Optional build macro TDM_DEMUX_PARITY_EN: 9-beat frames (8 data bits followed by
// one even-parity bit) and an extra o_parity_err output registered with o_dout.
module tdm_demux_1x8 #(
    parameter int CH        = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_sync_clr,
    input  logic          i_din,
    input  logic          i_din_valid,
    output logic          o_din_ready,
    output logic [CH-1:0] o_dout,
    output logic          o_dout_valid,
    input  logic          i_dout_ready,
`ifdef TDM_DEMUX_PARITY_EN
    output logic          o_parity_err,
`endif
    output logic [2:0]    o_ch_idx
);

`ifdef TDM_DEMUX_PARITY_EN
    // The counter needs a ninth value for the parity beat.
    localparam int             CW       = 4;
    localparam logic [CW-1:0]  LAST_CNT = 4'd8;
`else
    localparam int             CW       = 3;
    localparam logic [CW-1:0]  LAST_CNT = 3'd7;
`endif

    typedef enum logic {
        COLLECT = 1'b0,
        STALL   = 1'b1
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_count;
    logic [CH-1:0]   r_collect;
    logic [CH-1:0]   r_dout;
    logic            r_dout_valid;

    logic            w_accept;
    logic            w_last;
    logic            w_data_beat;
    logic [2:0]      w_slot;
    logic [CH-1:0]   w_word;
    logic            w_load_new;
    logic            w_enter_stall;
    logic            w_release;

`ifdef TDM_DEMUX_PARITY_EN
    logic            r_parity_err;
    logic            r_held_parity_err;
    logic            w_parity_err;

    // The parity beat (count 8) carries no data and reports slot 0.
    assign w_data_beat  = ~r_count[3];
    assign w_parity_err = (^r_collect) ^ i_din;
    assign o_parity_err = r_parity_err;
`else
    assign w_data_beat  = 1'b1;
`endif

    assign o_din_ready  = i_rst_n && (r_state == COLLECT);
    assign o_dout       = r_dout;
    assign o_dout_valid = r_dout_valid;
    assign o_ch_idx     = w_slot;

    assign w_accept      = i_din_valid && o_din_ready;
    assign w_last        = (r_count == LAST_CNT);
    assign w_load_new    = (r_state == COLLECT) && w_accept && w_last &&
                           (!r_dout_valid || i_dout_ready);
    assign w_enter_stall = (r_state == COLLECT) && w_accept && w_last &&
                           r_dout_valid && !i_dout_ready;
    assign w_release     = (r_state == STALL) && i_dout_ready;

    // Map the beat counter onto the channel slot the current bit belongs to.
    always_comb begin
        w_slot = 3'd0;
        if (w_data_beat) begin
            w_slot = MSB_FIRST ? (3'd7 - r_count[2:0]) : r_count[2:0];
        end
    end

    // Collect register with the current bit merged into its slot.
    always_comb begin
        w_word = r_collect;
        if (w_data_beat) begin
            w_word[w_slot] = i_din;
        end
    end

    // Frame assembly, output register and COLLECT/STALL control.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= COLLECT;
            r_count      <= '0;
            r_collect    <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
        end else if (i_sync_clr) begin
            r_state      <= COLLECT;
            r_count      <= '0;
            r_collect    <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
        end else begin
            case (r_state)
                COLLECT: begin
                    if (r_dout_valid && i_dout_ready) begin
                        r_dout_valid <= 1'b0;
                    end
                    if (w_accept) begin
                        if (w_last) begin
                            r_count <= '0;
                            if (w_load_new) begin
                                r_dout       <= w_word;
                                r_dout_valid <= 1'b1;
                                r_collect    <= '0;
                            end else begin
                                r_collect <= w_word;
                                r_state   <= STALL;
                            end
                        end else begin
                            r_count   <= r_count + 1'b1;
                            r_collect <= w_word;
                        end
                    end
                end
                STALL: begin
                    if (w_release) begin
                        r_dout    <= r_collect;
                        r_collect <= '0;
                        r_state   <= COLLECT;
                    end
                end
                default: begin
                    r_state <= COLLECT;
                end
            endcase
        end
    end

`ifdef TDM_DEMUX_PARITY_EN
    // Parity error travels with the word: loaded with o_dout, parked alongside a stalled word.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_parity_err      <= 1'b0;
            r_held_parity_err <= 1'b0;
        end else if (i_sync_clr) begin
            r_parity_err      <= 1'b0;
            r_held_parity_err <= 1'b0;
        end else if (w_load_new) begin
            r_parity_err <= w_parity_err;
        end else if (w_enter_stall) begin
            r_held_parity_err <= w_parity_err;
        end else if (w_release) begin
            r_parity_err <= r_held_parity_err;
        end
    end
`endif

endmodule

// File: tb/tb_tdm_demux_1x8.sv
// tb_tdm_demux_1x8 : directed bench for tdm_demux_1x8.
// Two instances share all inputs: dutA is LSB-first (MSB_FIRST=0), dutB is MSB-first.
// Honours TDM_DEMUX_PARITY_EN by appending the parity beat to every frame.
module tb_tdm_demux_1x8;

    logic       clk;
    logic       rstN;
    logic       syncClr;
    logic       din;
    logic       dinValid;
    logic       doutReady;

    logic       dinReadyA, dinReadyB;
    logic [7:0] doutA, doutB;
    logic       doutValidA, doutValidB;
    logic [2:0] chIdxA, chIdxB;
`ifdef TDM_DEMUX_PARITY_EN
    logic       parityErrA, parityErrB;
`endif

    int errorCount = 0;
    int checkCount = 0;

    tdm_demux_1x8 #(.CH(8), .MSB_FIRST(1'b0)) dutA (
        .i_clk        (clk),
        .i_rst_n      (rstN),
        .i_sync_clr   (syncClr),
        .i_din        (din),
        .i_din_valid  (dinValid),
        .o_din_ready  (dinReadyA),
        .o_dout       (doutA),
        .o_dout_valid (doutValidA),
        .i_dout_ready (doutReady),
`ifdef TDM_DEMUX_PARITY_EN
        .o_parity_err (parityErrA),
`endif
        .o_ch_idx     (chIdxA)
    );

    tdm_demux_1x8 #(.CH(8), .MSB_FIRST(1'b1)) dutB (
        .i_clk        (clk),
        .i_rst_n      (rstN),
        .i_sync_clr   (syncClr),
        .i_din        (din),
        .i_din_valid  (dinValid),
        .o_din_ready  (dinReadyB),
        .o_dout       (doutB),
        .o_dout_valid (doutValidB),
        .i_dout_ready (doutReady),
`ifdef TDM_DEMUX_PARITY_EN
        .o_parity_err (parityErrB),
`endif
        .o_ch_idx     (chIdxB)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs on the falling edge; return 1 ns after the rising edge.
    task automatic applyStimulus(input logic bitIn, input logic validIn, input logic readyIn, input logic clrIn);
        @(negedge clk);
        din       = bitIn;
        dinValid  = validIn;
        doutReady = readyIn;
        syncClr   = clrIn;
        @(posedge clk);
        #1;
    endtask

    // Send one frame LSB-first with no gaps, plus the parity beat when that build is active.
    task automatic sendFrame(input logic [7:0] word, input logic parityBit, input logic readyIn);
        for (int k = 0; k < 8; k++) begin
            applyStimulus(word[k], 1'b1, readyIn, 1'b0);
        end
`ifdef TDM_DEMUX_PARITY_EN
        applyStimulus(parityBit, 1'b1, readyIn, 1'b0);
`else
        if (parityBit !== ^word) begin
            $display("[TB] note: parity bit ignored in this build");
        end
`endif
    endtask

    initial begin
        logic [7:0] gapWord;
        int         gap;

        rstN      = 1'b0;
        syncClr   = 1'b0;
        din       = 1'b1;
        dinValid  = 1'b1;
        doutReady = 1'b0;

        // Reset held with din_valid asserted.
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_dout",      doutA,              8'h00);
        checkOutput("reset_valid",     {7'd0, doutValidA}, 8'h00);
        checkOutput("reset_chidx",     {5'd0, chIdxA},     8'h00);
        checkOutput("reset_chidxB",    {5'd0, chIdxB},     8'h07);
        checkOutput("reset_dinready",  {7'd0, dinReadyA},  8'h00);
        @(negedge clk);
        rstN     = 1'b1;
        dinValid = 1'b0;
        #1;
        checkOutput("release_dinready", {7'd0, dinReadyA}, 8'h01);

        // Basic frame 1,0,1,1,0,0,1,0.
        sendFrame(8'h4D, 1'b0, 1'b1);
        checkOutput("basic_doutA",  doutA,              8'h4D);
        checkOutput("basic_doutB",  doutB,              8'hB2);
        checkOutput("basic_valid",  {7'd0, doutValidA}, 8'h01);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("basic_pulse",  {7'd0, doutValidA}, 8'h00);

        // Backpressure: two frames with the consumer stalled.
        sendFrame(8'hA5, 1'b0, 1'b0);
        checkOutput("bp_first_dout",  doutA,              8'hA5);
        checkOutput("bp_first_valid", {7'd0, doutValidA}, 8'h01);
        sendFrame(8'h3C, 1'b0, 1'b0);
        checkOutput("bp_stall_dout",  doutA,              8'hA5);
        checkOutput("bp_stall_ready", {7'd0, dinReadyA},  8'h00);
        checkOutput("bp_stall_valid", {7'd0, doutValidA}, 8'h01);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("bp_release_dout",  doutA,              8'h3C);
        checkOutput("bp_release_valid", {7'd0, doutValidA}, 8'h01);
        checkOutput("bp_release_ready", {7'd0, dinReadyA},  8'h01);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("bp_drain_valid", {7'd0, doutValidA}, 8'h00);

        // Gapped input: ch_idx must hold while din_valid is low.
        gapWord = 8'h4D;
        for (int k = 0; k < 8; k++) begin
            gap = int'($urandom_range(3, 0));
            for (int g = 0; g < gap; g++) begin
                applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
                checkOutput("gap_chidx", {5'd0, chIdxA}, 8'(k));
            end
            checkOutput("gap_novalid", {7'd0, doutValidA}, 8'h00);
            applyStimulus(gapWord[k], 1'b1, 1'b1, 1'b0);
        end
`ifdef TDM_DEMUX_PARITY_EN
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
`endif
        checkOutput("gap_dout",  doutA,              8'h4D);
        checkOutput("gap_valid", {7'd0, doutValidA}, 8'h01);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);

        // sync_clr after five ones; the beat with sync_clr is dropped.
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        end
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
        checkOutput("clr_chidx",  {5'd0, chIdxA},     8'h00);
        checkOutput("clr_chidxB", {5'd0, chIdxB},     8'h07);
        checkOutput("clr_valid",  {7'd0, doutValidA}, 8'h00);
        checkOutput("clr_dout",   doutA,              8'h00);
        sendFrame(8'hFF, 1'b0, 1'b1);
        checkOutput("clr_frame_dout", doutA, 8'hFF);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);

        // Asynchronous reset pulse after three bits.
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        end
        @(negedge clk);
        dinValid = 1'b0;
        rstN     = 1'b0;
        #1;
        checkOutput("rst_mid_chidx", {5'd0, chIdxA},    8'h00);
        checkOutput("rst_mid_ready", {7'd0, dinReadyA}, 8'h00);
        @(negedge clk);
        rstN = 1'b1;
        sendFrame(8'h0F, 1'b0, 1'b1);
        checkOutput("rst_frame_doutA", doutA, 8'h0F);
        checkOutput("rst_frame_doutB", doutB, 8'hF0);

`ifdef TDM_DEMUX_PARITY_EN
        // Parity: 8'h4D has four ones, so parity bit 0 is correct and 1 is an error.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        sendFrame(8'h4D, 1'b0, 1'b1);
        checkOutput("par_ok_dout", doutA,              8'h4D);
        checkOutput("par_ok_err",  {7'd0, parityErrA}, 8'h00);
        sendFrame(8'h4D, 1'b1, 1'b1);
        checkOutput("par_bad_dout", doutA,              8'h4D);
        checkOutput("par_bad_err",  {7'd0, parityErrA}, 8'h01);
        checkOutput("par_bad_errB", {7'd0, parityErrB}, 8'h01);
`endif

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
